// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters producing HSYNC/VSYNC/DE, line/frame strobes and X/Y, delayed 1+PIPE cycles.
// Define VTG_CELL_SCALE_EN for divider-free CELL_X/CELL_Y scaling; without it those ports stay 0.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int PIPE = 1,
    parameter int SCALE_X = 10,
    parameter int SCALE_Y = 15,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW = $clog2(H_TOTAL),
    localparam int YW = $clog2(V_TOTAL),
    localparam int CXN = (H_ACTIVE + SCALE_X - 1) / SCALE_X,
    localparam int CYN = (V_ACTIVE + SCALE_Y - 1) / SCALE_Y,
    localparam int CXW = CXN > 1 ? $clog2(CXN) : 1,
    localparam int CYW = CYN > 1 ? $clog2(CYN) : 1
) (
    input  logic           CLK_25MHZ,
    input  logic           RESET,
    input  logic           ENABLE,
    output logic           VGA_HSYNC,
    output logic           VGA_VSYNC,
    output logic           VGA_DE,
    output logic [XW-1:0]  X,
    output logic [YW-1:0]  Y,
    output logic           LINE_START,
    output logic           FRAME_START,
    output logic [CXW-1:0] CELL_X,
    output logic [CYW-1:0] CELL_Y
);
    localparam int OW = 5 + XW + YW + CXW + CYW;

    logic run, go, h_last, v_last, h_adv;
    logic [XW-1:0] h, h_n;
    logic [YW-1:0] v, v_n;
    logic de, hs_act, vs_act, ls, fs, hs_q, vs_q;
    logic [CXW-1:0] cx_o;
    logic [CYW-1:0] cy_o;
    logic [PIPE:0][OW-1:0] pipe;

    // run marks a counting state; the first enabled edge only arms it so the raster starts at (0,0)
    always_comb begin
        go = ENABLE && run;
        h_last = h == XW'(H_TOTAL - 1);
        v_last = v == YW'(V_TOTAL - 1);
        h_adv = go && !h_last;
        h_n = h_adv ? h + 1'b1 : '0;
        v_n = !go ? '0 : !h_last ? v : v_last ? '0 : v + 1'b1;
        de = run && int'(h) < H_ACTIVE && int'(v) < V_ACTIVE;
        hs_act = run && int'(h) >= H_ACTIVE + H_FP && int'(h) < H_ACTIVE + H_FP + H_SYNC;
        vs_act = run && int'(v) >= V_ACTIVE + V_FP && int'(v) < V_ACTIVE + V_FP + V_SYNC;
        ls = run && h == '0;
        fs = ls && v == '0;
    end

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            run <= 1'b0;
            h <= '0;
            v <= '0;
        end else begin
            run <= ENABLE;
            h <= h_n;
            v <= v_n;
        end
    end

`ifdef VTG_CELL_SCALE_EN
    localparam int SXW = SCALE_X > 1 ? $clog2(SCALE_X) : 1;
    localparam int SYW = SCALE_Y > 1 ? $clog2(SCALE_Y) : 1;

    logic [SXW-1:0] sx, sx_n;
    logic [SYW-1:0] sy, sy_n;
    logic [CXW-1:0] cx, cx_n;
    logic [CYW-1:0] cy, cy_n;
    logic sx_wrap, sy_wrap, v_step;

    // cell counters track h/v in lockstep; a trailing partial cell naturally gets the next index
    always_comb begin
        sx_wrap = sx == SXW'(SCALE_X - 1);
        sy_wrap = sy == SYW'(SCALE_Y - 1);
        v_step = go && h_last && !v_last;
        sx_n = h_adv && !sx_wrap ? sx + 1'b1 : '0;
        cx_n = h_adv ? cx + CXW'(sx_wrap) : '0;
        sy_n = !go ? '0 : !h_last ? sy : v_step && !sy_wrap ? sy + 1'b1 : '0;
        cy_n = !go ? '0 : !h_last ? cy : v_step ? cy + CYW'(sy_wrap) : '0;
        cx_o = de ? cx : '0;
        cy_o = de ? cy : '0;
    end

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            sx <= '0;
            sy <= '0;
            cx <= '0;
            cy <= '0;
        end else begin
            sx <= sx_n;
            sy <= sy_n;
            cx <= cx_n;
            cy <= cy_n;
        end
    end
`else
    assign cx_o = '0;
    assign cy_o = '0;
`endif

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {ls, fs, de, hs_act, vs_act, h, v, cx_o, cy_o};
            for (int i = 1; i <= PIPE; i++) pipe[i] <= pipe[i - 1];
        end
    end

    // syncs travel as "asserted" flags so a cleared pipeline reads as the idle level
    assign {LINE_START, FRAME_START, VGA_DE, hs_q, vs_q, X, Y, CELL_X, CELL_Y} = pipe[PIPE];
    assign VGA_HSYNC = hs_q ? HS_POL : !HS_POL;
    assign VGA_VSYNC = vs_q ? VS_POL : !VS_POL;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench driving two small-raster instances (PIPE=3/HS_POL=1 and PIPE=0/HS_POL=0).
module tb_video_timing_gen;
    typedef struct packed {
        logic ls, fs, de, hs, vs;
        logic [4:0] x;
        logic [3:0] y;
        logic [1:0] cx;
        logic [0:0] cy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic hs0, vs0, de0, ls0, fs0, hs3, vs3, de3, ls3, fs3;
    logic [4:0] x0, x3;
    logic [3:0] y0, y3;
    logic [1:0] cx0, cx3;
    logic [0:0] cy0, cy3;

    exp_t q0[$];
    exp_t q3[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit run_m = 0, measure = 0;
    int t_m = 0;
    int last_fs = -1, last_ls = -1, de_run = 0, hs_run = 0;
    logic hs_prev = 1'b0, de_prev = 1'b0;

    video_timing_gen #(.H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
        .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(3), .SCALE_X(5), .SCALE_Y(4)) dut3 (
        .CLK_25MHZ(clk), .RESET(rst), .ENABLE(en), .VGA_HSYNC(hs3), .VGA_VSYNC(vs3), .VGA_DE(de3),
        .X(x3), .Y(y3), .LINE_START(ls3), .FRAME_START(fs3), .CELL_X(cx3), .CELL_Y(cy3));

    video_timing_gen #(.H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
        .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(0), .SCALE_X(5), .SCALE_Y(4)) dut0 (
        .CLK_25MHZ(clk), .RESET(rst), .ENABLE(en), .VGA_HSYNC(hs0), .VGA_VSYNC(vs0), .VGA_DE(de0),
        .X(x0), .Y(y0), .LINE_START(ls0), .FRAME_START(fs0), .CELL_X(cx0), .CELL_Y(cy0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // turn asserted flags into pin levels for the given HSYNC polarity (VSYNC is active-low on both)
    function automatic exp_t lv(input exp_t e, input bit hp);
        exp_t r = e;
        r.hs = e.hs ? hp : !hp;
        r.vs = e.vs ? 1'b0 : 1'b1;
        return r;
    endfunction

    // reference raster: 18 clocks/line, 10 lines/frame, HSYNC on h 14..16, VSYNC on v 7..8, cells 5x4
    task automatic step();
        exp_t e;
        int hh, vv;
        @(posedge clk);
        if (rst || !en) run_m = 0;
        else if (!run_m) begin run_m = 1; t_m = 0; end
        else t_m++;
        hh = t_m % 18;
        vv = (t_m / 18) % 10;
        e = '0;
        if (run_m) begin
            e.x = 5'(hh);
            e.y = 4'(vv);
            e.de = hh < 12 && vv < 6;
            e.hs = hh >= 14 && hh < 17;
            e.vs = vv >= 7 && vv < 9;
            e.ls = hh == 0;
            e.fs = hh == 0 && vv == 0;
`ifdef VTG_CELL_SCALE_EN
            if (e.de) begin
                e.cx = 2'(hh / 5);
                e.cy = 1'(vv / 4);
            end
`endif
        end
        q0.push_back(e);
        q3.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q0.size() > 1) begin
            e = q0.pop_front();
            chk($sformatf("sb_pipe0@%0d", cyc), 32'({ls0, fs0, de0, hs0, vs0, x0, y0, cx0, cy0}), 32'(lv(e, 1'b0)));
        end
        if (q3.size() > 4) begin
            e = q3.pop_front();
            chk($sformatf("sb_pipe3@%0d", cyc), 32'({ls3, fs3, de3, hs3, vs3, x3, y3, cx3, cy3}), 32'(lv(e, 1'b1)));
        end
        if (measure) begin
            if (fs3) begin
                if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'd180);
                last_fs = cyc;
            end
            if (ls3) begin
                if (last_ls >= 0) chk("line_period", 32'(cyc - last_ls), 32'd18);
                last_ls = cyc;
            end
            if (de3 && !de_prev) chk("de_line", 32'(y3 < 4'd6), 32'd1);
            if (de3) de_run++;
            else if (de_run != 0) begin chk("de_run", 32'(de_run), 32'd12); de_run = 0; end
            if (hs3 && !hs_prev) chk("hs_start_x", 32'(x3), 32'd14);
            if (hs3) hs_run++;
            else if (hs_run != 0) begin chk("hs_run", 32'(hs_run), 32'd3); hs_run = 0; end
            if (!vs3) chk("vs_line", 32'(y3 == 4'd7 || y3 == 4'd8), 32'd1);
        end
        de_prev = de3;
        hs_prev = hs3;
    end

    initial begin
        en = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset_pipe0", 32'({ls0, fs0, de0, hs0, vs0, x0, y0, cx0, cy0}), 32'(lv('0, 1'b0)));
        chk("reset_pipe3", 32'({ls3, fs3, de3, hs3, vs3, x3, y3, cx3, cy3}), 32'(lv('0, 1'b1)));
        repeat (3) step();
        rst = 1'b0;
        measure = 1;
        repeat (430) step();
        en = 1'b0;
        measure = 0;
        repeat (20) step();
        en = 1'b1;
        repeat (200) step();
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (40) step();
        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, active pixels per line; H_FP 16, h front porch; H_SYNC 96, h sync width; H_BP 48, h back porch.
REQ-002 SHALL have parameters: V_ACTIVE 480, active lines; V_FP 10, v front porch; V_SYNC 2, v sync width; V_BP 33, v back porch.
REQ-003 SHALL have parameters: HS_POL 0, asserted HSYNC level; VS_POL 0, asserted VSYNC level; PIPE 1, extra output delay stages, range 0..4; SCALE_X 10, pixels per cell; SCALE_Y 15, lines per cell.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: CLK_25MHZ in 1, pixel clock, all logic on rising edge; RESET in 1, asynchronous active-high reset.
REQ-005 SHALL have port ENABLE in 1, run when high, hold timing idle when low.
REQ-006 SHALL have ports VGA_HSYNC out 1, VGA_VSYNC out 1, VGA_DE out 1, the video timing outputs.
REQ-007 SHALL have ports X out clog2(H_ACTIVE+H_FP+H_SYNC+H_BP), Y out clog2(V_ACTIVE+V_FP+V_SYNC+V_BP), the raw counters.
REQ-008 SHALL have ports LINE_START out 1, high at h=0; FRAME_START out 1, high at h=0 and v=0.
REQ-009 SHALL have ports CELL_X out clog2(ceil(H_ACTIVE/SCALE_X)) and CELL_Y out clog2(ceil(V_ACTIVE/SCALE_Y)), scaled active-area coordinates.

Function
REQ-010 SHALL count h from 0 to H_TOTAL-1 (H_TOTAL = sum of H_* parameters) and wrap to 0; v SHALL increment on h wrap and wrap to 0 after V_TOTAL-1.
REQ-011 SHALL compute DE = (h < H_ACTIVE) and (v < V_ACTIVE).
REQ-012 SHALL assert HSYNC (level HS_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and drive the non-asserted level (~HS_POL) otherwise; VSYNC likewise over lines [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) with VS_POL.
REQ-013 SHALL register all outputs from the counter state, giving latency of 1+PIPE cycles; all outputs SHALL be delayed equally.
REQ-014 SHALL derive CELL_X/CELL_Y incrementally with sub-counters, without dividers: CELL_X = floor(h/SCALE_X) and CELL_Y = floor(v/SCALE_Y) while DE is asserted, and 0 outside the active area.
REQ-015 SHALL, when H_ACTIVE is not a multiple of SCALE_X, give the trailing partial cell the next index; the same rule SHALL apply to Y.
REQ-016 SHALL, while ENABLE is low, force h=v=0 and all sub-counters to 0 on each clock, and drive DE=0, HSYNC and VSYNC non-asserted, and LINE_START=FRAME_START=0 on the outputs after the pipeline latency.
REQ-017 SHALL, when ENABLE deasserts mid-frame, abandon the frame on the next edge; on re-assertion, counting SHALL restart at (0,0) with FRAME_START.
REQ-018 SHALL require H_SYNC, V_SYNC, SCALE_X and SCALE_Y to be at least 1; all porches may be 0.

Reset
REQ-019 SHALL, on RESET, asynchronously clear h, v, sub-counters, cells and every pipeline stage.
REQ-020 SHALL drive these outputs during reset: DE=0, HSYNC=~HS_POL, VSYNC=~VS_POL, X=Y=0, CELL_X=CELL_Y=0, LINE_START=FRAME_START=0.
REQ-021 SHALL, on the first edge after RESET falls with ENABLE high, put the counters at (0,0); outputs SHALL reflect this state 1+PIPE edges later.

Configuration
REQ-022 SHALL implement cell scaling only when macro VTG_CELL_SCALE_EN is defined; without it, CELL_X and CELL_Y SHALL remain as ports tied to 0, and no sub-counter logic SHALL be synthesised.

Verification
REQ-023 SHALL check, with defaults, that after reset release FRAME_START pulses every 420000 cycles, LINE_START every 800 cycles, and DE is high for 640 consecutive cycles on lines 0..479 only.
REQ-024 SHALL check, with defaults, that HSYNC is low for exactly 96 cycles starting at X=656, and that VSYNC is low only on lines 490..491.
REQ-025 SHALL check, with VTG_CELL_SCALE_EN defined, that X=9 gives CELL_X=0, X=10 gives 1, X=639 gives 63, and Y=479 gives CELL_Y=31; CELL_X=0 at X=700.
REQ-026 SHALL check that ENABLE dropped at X=100,Y=200 gives DE=0 and non-asserted syncs 1+PIPE cycles later; on re-enable, FRAME_START arrives 1+PIPE cycles after the rising edge.
REQ-027 SHALL check, with PIPE=0 versus PIPE=3, that all outputs shift by exactly 3 cycles; with HS_POL=1, the HSYNC waveform is inverted.
REQ-028 SHALL check, with small parameters H_ACTIVE=4, H_FP=0, H_SYNC=1, H_BP=0, V_ACTIVE=2, V_FP=0, V_SYNC=1, V_BP=0, SCALE_X=3, that h wraps at 4, v wraps at 2, and CELL_X sequence 0,0,0,1 is produced.
